// File: rtl/ahfp_pkg.sv
// Shared constants, opcodes and FSM state type for the ahfp_acc floating-point accumulator.
package ahfp_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int WORD_W = SIGN_W + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] BIAS      = 8'd127;
  localparam logic [EXP_W-1:0] EXP_ONES  = 8'hFF;
  localparam logic [EXP_W-1:0] MAX_SHIFT = 8'd26;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ACC   = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK
  } state_t;

endpackage

// File: rtl/ahfp_lzc_shift.sv
// Combinational 25-bit leading-zero count and matching left shift for normalisation.
module ahfp_lzc_shift (
  input  logic [24:0] i_data,
  output logic [4:0]  o_lz,
  output logic [24:0] o_shifted
);

  // Scanning upward lets the highest set bit win; an all-zero input reports 25.
  always_comb begin
    o_lz = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (i_data[i]) o_lz = 5'(24 - i);
    end
    o_shifted = i_data << o_lz;
  end

endmodule

// File: rtl/ahfp_acc.sv
// Multi-cycle single-precision accumulator (CLEAR / ACC / READ) with denormal flush.
// Define AHFP_ACC_ROUND_EN for round-half-up in PACK; otherwise results are truncated.
module ahfp_acc
  import ahfp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [1:0]        n,
  input  logic [WORD_W-1:0] dataa,
  output logic              done,
  output logic [WORD_W-1:0] result
);

  state_t              r_state;
  logic [1:0]          r_op;
  logic [WORD_W-1:0]   r_operand;
  logic [WORD_W-1:0]   r_acc;
  logic [WORD_W-1:0]   r_result;
  logic                r_done;
  logic                r_sign;
  logic                r_sub;
  logic signed [9:0]   r_exp;
  logic [MANT_W-1:0]   r_mBig;
  logic [MANT_W-1:0]   r_mSmall;
  logic [MANT_W-1:0]   r_mant;
  logic [MANT_W:0]     r_sum;
  logic                r_g;
  logic                r_s;
  logic                r_special;
  logic [WORD_W-1:0]   r_specVal;

  logic [EXP_W-1:0]    w_aExp, w_bExp, w_bigExp, w_smallExp, w_diff;
  logic [MANT_W-1:0]   w_aMant, w_bMant, w_bigMant, w_smallMant, w_alignMant;
  logic                w_aSign, w_bSign, w_aBig, w_bigSign, w_alignG, w_alignS;
  logic [47:0]         w_wide;
  logic                w_special;
  logic [WORD_W-1:0]   w_specVal;
  logic [MANT_W:0]     w_addSum;
  logic [MANT_W+1:0]   w_subExt;
  logic [4:0]          w_lz;
  logic [24:0]         w_shifted;
  logic [MANT_W-1:0]   w_normMant;
  logic                w_normG, w_normS;
  logic signed [9:0]   w_normExp;
  logic [MANT_W-1:0]   w_packMant;
  logic signed [9:0]   w_packExp;
  logic [WORD_W-1:0]   w_packed;

  assign done   = r_done;
  assign result = r_result;

  // Operand unpack with denormal flush, magnitude ordering and alignment shift.
  always_comb begin
    w_aExp      = r_acc[30:23];
    w_bExp      = r_operand[30:23];
    w_aMant     = (w_aExp == '0) ? '0 : {1'b1, r_acc[22:0]};
    w_bMant     = (w_bExp == '0) ? '0 : {1'b1, r_operand[22:0]};
    w_aSign     = (w_aExp == '0) ? 1'b0 : r_acc[31];
    w_bSign     = (w_bExp == '0) ? 1'b0 : r_operand[31];
    w_aBig      = {w_aExp, w_aMant[22:0]} >= {w_bExp, w_bMant[22:0]};
    w_bigExp    = w_aBig ? w_aExp  : w_bExp;
    w_smallExp  = w_aBig ? w_bExp  : w_aExp;
    w_bigMant   = w_aBig ? w_aMant : w_bMant;
    w_smallMant = w_aBig ? w_bMant : w_aMant;
    w_bigSign   = w_aBig ? w_aSign : w_bSign;
    w_diff      = w_bigExp - w_smallExp;
    w_wide      = {w_smallMant, 24'd0} >> w_diff;
    if (w_diff >= MAX_SHIFT) begin
      w_alignMant = '0;
      w_alignG    = 1'b0;
      w_alignS    = |w_smallMant;
    end else begin
      w_alignMant = w_wide[47:24];
      w_alignG    = w_wide[23];
      w_alignS    = |w_wide[22:0];
    end
    w_special = (w_aExp == EXP_ONES) || (w_bExp == EXP_ONES);
    w_specVal = (w_aExp == EXP_ONES) ? r_acc : {r_operand[31], EXP_ONES, 23'd0};
  end

  assign w_addSum = {1'b0, r_mBig} + {1'b0, r_mSmall};
  assign w_subExt = {r_mBig, 2'b00} - {r_mSmall, r_g, r_s};

  ahfp_lzc_shift u_lzc (
    .i_data    ({r_sum[23:0], r_g}),
    .o_lz      (w_lz),
    .o_shifted (w_shifted)
  );

  always_comb begin
    if (r_sum[24]) begin
      w_normMant = r_sum[24:1];
      w_normG    = r_sum[0];
      w_normS    = r_g | r_s;
      w_normExp  = r_exp + 10'sd1;
    end else begin
      w_normMant = w_shifted[24:1];
      w_normG    = w_shifted[0];
      w_normS    = r_s;
      w_normExp  = r_exp - $signed({5'd0, w_lz});
    end
    if (w_normExp <= 10'sd0) begin
      w_normMant = '0;
      w_normG    = 1'b0;
      w_normS    = 1'b0;
    end
  end

`ifdef AHFP_ACC_ROUND_EN
  logic [MANT_W:0] w_round;
  assign w_round    = {1'b0, r_mant} + {{MANT_W{1'b0}}, r_g};
  assign w_packMant = w_round[MANT_W] ? w_round[MANT_W:1] : w_round[MANT_W-1:0];
  assign w_packExp  = w_round[MANT_W] ? r_exp + 10'sd1 : r_exp;
`else
  assign w_packMant = r_mant;
  assign w_packExp  = r_exp;
`endif

  // A cleared hidden bit after normalisation means the sum collapsed to zero.
  always_comb begin
    if (r_special)                   w_packed = r_specVal;
    else if (!w_packMant[23])        w_packed = '0;
    else if (w_packExp >= 10'sd255)  w_packed = {r_sign, EXP_ONES, 23'd0};
    else                             w_packed = {r_sign, w_packExp[7:0], w_packMant[22:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_sign    <= 1'b0;
      r_sub     <= 1'b0;
      r_exp     <= '0;
      r_mBig    <= '0;
      r_mSmall  <= '0;
      r_mant    <= '0;
      r_sum     <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_special <= 1'b0;
      r_specVal <= '0;
    end else if (clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= n;
            r_operand <= dataa;
            r_state   <= (n == OP_ACC) ? S_ALIGN : S_PACK;
          end
        end
        S_ALIGN: begin
          r_sign    <= w_bigSign;
          r_sub     <= w_aSign != w_bSign;
          r_exp     <= $signed({2'b00, w_bigExp});
          r_mBig    <= w_bigMant;
          r_mSmall  <= w_alignMant;
          r_g       <= w_alignG;
          r_s       <= w_alignS;
          r_special <= w_special;
          r_specVal <= w_specVal;
          r_state   <= S_ADD;
        end
        S_ADD: begin
          if (r_sub) begin
            r_sum <= {1'b0, w_subExt[MANT_W+1:2]};
            r_g   <= w_subExt[1];
            r_s   <= w_subExt[0];
          end else begin
            r_sum <= w_addSum;
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_mant  <= w_normMant;
          r_g     <= w_normG;
          r_s     <= w_normS;
          r_exp   <= w_normExp;
          r_state <= S_PACK;
        end
        S_PACK: begin
          r_done <= 1'b1;
          case (r_op)
            OP_CLEAR: begin
              r_acc    <= '0;
              r_result <= '0;
            end
            OP_ACC: begin
              r_acc    <= w_packed;
              r_result <= w_packed;
            end
            default: r_result <= r_acc;
          endcase
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ahfp_acc.md
# ahfp_acc

Multi-cycle single-precision floating-point accumulator, placed directly downstream of the floating-point multiplier as a custom-instruction stage. It consumes each IEEE-754 product the multiplier emits and folds it into an internal running sum, so a dot product needs one multiply and one accumulate per element. Operation is selected per instruction through the `n` field (clear / accumulate / read). It uses the `start`/`done` multi-cycle handshake and flushes denormals to zero, matching the multiplier.

## Interface
- `BIAS`, 127: exponent bias.
- `MAX_SHIFT`, 26: alignment shift at or beyond which the smaller operand contributes only sticky.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clk_en` in 1: all state advances only when high; when low, every register holds.
- `start` in 1: instruction request; sampled only in IDLE with `clk_en` high.
- `n` in 2: operation select. 0 = CLEAR, 1 = ACC, 2 = READ, 3 = reserved (behaves as READ).
- `dataa` in 32: IEEE-754 single operand, normally the multiplier `result`; sampled with `start`.
- `done` out 1: one-cycle completion pulse; reset value 0.
- `result` out 32: accumulator value after the operation; reset value 0x00000000.

## Operation
- State machine: IDLE, ALIGN, ADD, NORM, PACK.
- **CLEAR:** sets acc to +0 and result to 0. Goes IDLE→PACK.
- **READ:** result ← acc; acc is unchanged. Goes IDLE→PACK.
- **ACC:** goes IDLE→ALIGN→ADD→NORM→PACK→IDLE.
- **Zero operands:** an operand with exponent 0 is treated as +0 (denormals are flushed).
- **ALIGN:**
  - Larger operand chosen by the {exp, mantissa} magnitude compare.
  - The smaller operand's 24-bit mantissa (hidden 1 included) shifts right by the exponent difference, keeping a guard bit and a sticky bit.
  - A difference ≥ `MAX_SHIFT` leaves only sticky.
- **ADD:**
  - Equal signs: 25-bit add.
  - Unequal signs: larger minus smaller.
  - Result sign is the larger operand's sign.
- **NORM:**
  - Carry out: shift right 1 and exp+1.
  - Otherwise: shift left by the leading-zero count and exp−lz.
  - Zero mantissa gives +0 (sign 0).
  - exp ≤ 0 gives +0.
- **PACK:**
  - Rounding applies (see Configuration); a rounding carry gives exp+1.
  - exp ≥ 255 saturates to {s, 0xFF, 0}.
  - Writes acc and result and pulses `done`.
- **Inf/NaN (exponent 255):**
  - An input with exponent 255 makes acc {sign, 0xFF, 0}.
  - Once acc has exponent 255, ACC leaves it unchanged until CLEAR or reset.
- **`start` while busy:** ignored; never queued.

## Timing
- `start` sampled at edge k.
- CLEAR/READ: `done` = 1 after edge k+1.
- ACC: `done` = 1 after edge k+4.
- `done` is high for exactly one `clk_en`-qualified cycle. A new `start` is accepted in the cycle `done` is high (FSM is back in IDLE at the next edge).
- `result` is registered and holds its value until the next PACK.
- `clk_en` low mid-operation stretches latency by one cycle per low cycle. With `clk_en` low and `done` high, `done` holds high.
- Reset asserted at any point, including mid-ACC: FSM goes to IDLE; acc, result and `done` go to 0 immediately.

## Configuration
- `AHFP_ACC_ROUND_EN` defined: round-half-up. PACK adds the guard bit to the 23-bit fraction (same scheme as the multiplier).
- `AHFP_ACC_ROUND_EN` undefined: truncation. Guard and sticky are discarded, and the rounding adder is not built.

## Structure
- Package `ahfp_pkg` holds:
  - field widths (sign 1, exponent 8, fraction 23);
  - `BIAS`;
  - exponent-all-ones constant;
  - opcode constants `OP_CLEAR`/`OP_ACC`/`OP_READ`;
  - the FSM state enum.
- One sub-module, `ahfp_lzc_shift`: combinational 25-bit leading-zero count plus left shift, used by NORM.

## Test plan
- Reset, then READ → `done` one cycle after `start`, result 0x00000000.
- CLEAR; ACC 0x3F800000; ACC 0x40000000; READ → result 0x40400000, with each ACC's `done` 4 cycles after `start`.
- ACC 0x3F800000 then ACC 0xBF800000 → result 0x00000000 (positive zero).
- acc = 0x3F800000; ACC 0x30800000 (shift 30) → result 0x3F800000.
- acc = 0x3F800000; ACC 0x33800000 → 0x3F800001 with `AHFP_ACC_ROUND_EN`, 0x3F800000 without.
- Overflow and reset:
  - ACC 0x7F000000 twice → 0x7F800000.
  - ACC 0x3F800000 → stays 0x7F800000.
  - Reset asserted during ALIGN of a new ACC → `done` 0, and a following READ returns 0x00000000.
